// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with pseudo-LRU replacement, beat-wise refill engine,
// global flush and hit/miss performance counters.
module icache_2way #(
  parameter int unsigned SETS       = 8,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [31:0]      req_addr,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [31:0]      resp_instr,
  output logic             resp_hit,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_data,
  input  logic             flush,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned OFF    = $clog2(LINE_WORDS);
  localparam int unsigned IDX    = $clog2(SETS);
  localparam int unsigned LINE_W = 32 - OFF - 2;
  localparam int unsigned TAG_W  = LINE_W - IDX;

  typedef enum logic [1:0] {StIdle, StRefill, StRespond} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0][1:0] valid_q;
  logic [SETS-1:0]      lru_q;
  logic [OFF-1:0]       beat_q;
  logic                 flush_pend_q;
  logic [LINE_W-1:0]    line_q;
  logic [OFF-1:0]       off_q;
  logic                 victim_q;
  logic                 resp_valid_q, resp_hit_q;
  logic [31:0]          resp_instr_q;
  logic [CNT_W-1:0]     hit_count_q, miss_count_q;

  logic [TAG_W-1:0] tag_q  [2][SETS];
  logic [31:0]      data_q [2][SETS][LINE_WORDS];

  logic [IDX-1:0]   req_idx, line_idx;
  logic [OFF-1:0]   req_off;
  logic [TAG_W-1:0] req_tag, line_tag;
  logic             hit0, hit1, hit, hit_way, victim;
  logic             accept, do_flush, refill_beat, last_beat;
  logic [31:0]      hit_word, refill_word;
  logic             unused_addr;

  assign req_idx     = req_addr[OFF+2 +: IDX];
  assign req_off     = req_addr[2 +: OFF];
  assign req_tag     = req_addr[31 -: TAG_W];
  assign line_idx    = line_q[IDX-1:0];
  assign line_tag    = line_q[LINE_W-1 -: TAG_W];
  assign unused_addr = ^req_addr[1:0];

  assign hit0     = valid_q[req_idx][0] && (tag_q[0][req_idx] == req_tag);
  assign hit1     = valid_q[req_idx][1] && (tag_q[1][req_idx] == req_tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit0 ? 1'b0 : 1'b1;
  assign hit_word = data_q[hit_way][req_idx][req_off];

  // Fill an empty way first; only evict by LRU when the set is full.
  assign victim = !valid_q[req_idx][0] ? 1'b0 :
                  !valid_q[req_idx][1] ? 1'b1 : lru_q[req_idx];

  // A flush deferred from a refill blocks the first idle cycle just like a live one.
  assign req_ready   = (state_q == StIdle) && !flush && !flush_pend_q;
  assign accept      = req_valid && req_ready;
  assign do_flush    = (state_q == StIdle) && (flush || flush_pend_q);
  assign refill_beat = (state_q == StRefill) && mem_ack;
  assign last_beat   = refill_beat && (beat_q == OFF'(LINE_WORDS - 1));

  // The requested word may be arriving on this very beat rather than sitting in the array.
  assign refill_word = (beat_q == off_q) ? mem_data : data_q[victim_q][line_idx][off_q];

  assign mem_req    = (state_q == StRefill);
  assign mem_addr   = {line_q, {(OFF + 2){1'b0}}};
  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;
  assign resp_hit   = resp_hit_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept && !hit) state_d = StRefill;
      StRefill:  if (last_beat) state_d = StRespond;
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      lru_q        <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      line_q       <= '0;
      off_q        <= '0;
      victim_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_instr_q <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      if (flush && (state_q != StIdle)) begin
        flush_pend_q <= 1'b1;
      end else if (do_flush) begin
        flush_pend_q <= 1'b0;
      end
      if (do_flush) valid_q <= '0;
      if (accept) begin
        if (hit) begin
          resp_valid_q     <= 1'b1;
          resp_hit_q       <= 1'b1;
          resp_instr_q     <= hit_word;
          lru_q[req_idx]   <= ~hit_way;
          hit_count_q      <= hit_count_q + CNT_W'(1);
        end else begin
          line_q       <= req_addr[31:OFF+2];
          off_q        <= req_off;
          victim_q     <= victim;
          miss_count_q <= miss_count_q + CNT_W'(1);
        end
      end
      if (refill_beat) beat_q <= beat_q + OFF'(1);
      if (last_beat) begin
        valid_q[line_idx][victim_q] <= 1'b1;
        lru_q[line_idx]             <= ~victim_q;
        resp_valid_q                <= 1'b1;
        resp_hit_q                  <= 1'b0;
        resp_instr_q                <= refill_word;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clock) begin
    if (refill_beat) data_q[victim_q][line_idx][beat_q] <= mem_data;
    if (last_beat) tag_q[victim_q][line_idx] <= line_tag;
  end

endmodule

// File: tb/tb_icache_2way.sv
// Directed self-checking bench for icache_2way: refill timing, hits, LRU, flush, ack gaps, reset.
module tb_icache_2way;

  logic        clock, reset_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_instr;
  logic        mem_req, mem_ack, flush;
  logic [31:0] mem_addr, mem_data;
  logic [15:0] hit_count, miss_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_base;
  int          tb_beat;

  icache_2way #(.SETS(8), .LINE_WORDS(4), .CNT_W(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_instr(resp_instr),
    .resp_hit  (resp_hit),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .flush     (flush),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory returns mem_base + beat number for the refill in progress.
  always @(posedge clock) begin
    if (!mem_req) tb_beat <= 0;
    else if (mem_ack) tb_beat <= tb_beat + 1;
  end
  assign mem_data = mem_base + tb_beat;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, output logic ok);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    ok = req_ready;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic got, output logic [31:0] instr, output logic hit,
                           output int n);
    n = 0;
    while (!resp_valid && n < 40) begin
      step();
      n++;
    end
    got   = resp_valid;
    instr = resp_instr;
    hit   = resp_hit;
  endtask

  task automatic do_req(input logic [31:0] a, output logic got, output logic [31:0] instr,
                        output logic hit);
    logic ok;
    int   n;
    issue(a, ok);
    wait_resp(got, instr, hit, n);
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; mem_ack = 1'b0; flush = 1'b0;
    mem_base = '0;
    repeat (3) step();
    checks++;
    if ({resp_valid, resp_hit, mem_req, resp_instr, mem_addr, hit_count, miss_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v%b h%b mreq%b instr %h maddr %h hc %0d mc %0d want all 0",
               resp_valid, resp_hit, mem_req, resp_instr, mem_addr, hit_count, miss_count);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_first_miss();
    logic ok;
    int   n = 0, nreq = 0;
    mem_base = 32'hA0;
    mem_ack  = 1'b1;
    issue(32'h40, ok);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL miss_memreq got req %b addr %h want 1 00000040", mem_req, mem_addr);
    end
    while (!resp_valid && n < 40) begin
      if (mem_req) nreq++;
      step();
      n++;
    end
    checks++;
    if (n !== 4 || nreq !== 4) begin
      errors++;
      $display("FAIL miss_latency got wait %0d memreq_cycles %0d want 4 4", n, nreq);
    end
    checks++;
    if ({resp_valid, resp_hit, resp_instr} !== {1'b1, 1'b0, 32'hA0}) begin
      errors++;
      $display("FAIL miss_resp got v%b h%b %h want v1 h0 000000a0", resp_valid, resp_hit,
               resp_instr);
    end
    checks++;
    if (miss_count !== 16'd1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL miss_count_ready got mc %0d ready %b want 1 0", miss_count, req_ready);
    end
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h44 + 32'(4 * i);
      step();
      checks++;
      if ({resp_valid, resp_hit, resp_instr} !== {1'b1, 1'b1, 32'hA1 + 32'(i)}) begin
        errors++;
        $display("FAIL b2b_hit%0d got v%b h%b %h want v1 h1 %h", i, resp_valid, resp_hit,
                 resp_instr, 32'hA1 + 32'(i));
      end
    end
    req_valid = 1'b0;
    checks++;
    if (hit_count !== 16'd3) begin
      errors++;
      $display("FAIL b2b_hit_count got %0d want 3", hit_count);
    end
  endtask

  task automatic test_lru();
    logic [31:0] addrs [5] = '{32'hC0, 32'h40, 32'h140, 32'h40, 32'hC0};
    logic [31:0] bases [5] = '{32'hB0, 32'h0, 32'hC0, 32'h0, 32'hB0};
    logic [32:0] expv  [5] = '{{1'b0, 32'hB0}, {1'b1, 32'hA0}, {1'b0, 32'hC0},
                               {1'b1, 32'hA0}, {1'b0, 32'hB0}};
    logic        got, hit;
    logic [31:0] instr;
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_base = bases[i];
      do_req(addrs[i], got, instr, hit);
      checks++;
      if ({got, hit, instr} !== {1'b1, expv[i]}) begin
        errors++;
        $display("FAIL lru_step%0d addr %h got v%b h%b %h want v1 h%b %h", i, addrs[i], got, hit,
                 instr, expv[i][32], expv[i][31:0]);
      end
    end
  endtask

  task automatic test_flush_idle();
    logic        got, hit;
    logic [31:0] instr;
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h40;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_ready got %b want 0", req_ready);
    end
    step();
    flush = 1'b0; req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_noaccept got v%b mreq%b want 0 0", resp_valid, mem_req);
    end
    mem_base = 32'hA0;
    do_req(32'h40, got, instr, hit);
    checks++;
    if ({got, hit, instr} !== {1'b1, 1'b0, 32'hA0}) begin
      errors++;
      $display("FAIL flush_idle_remiss got v%b h%b %h want v1 h0 000000a0", got, hit, instr);
    end
    checks++;
    if (hit_count !== 16'd5 || miss_count !== 16'd5) begin
      errors++;
      $display("FAIL counters got hc %0d mc %0d want 5 5", hit_count, miss_count);
    end
  endtask

  task automatic test_flush_refill();
    logic        ok, got, hit;
    logic [31:0] instr;
    int          n;
    mem_ack  = 1'b1;
    mem_base = 32'hD0;
    issue(32'h80, ok);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_resp(got, instr, hit, n);
    checks++;
    if ({got, hit, instr} !== {1'b1, 1'b0, 32'hD0} || n !== 2) begin
      errors++;
      $display("FAIL flush_refill_resp got v%b h%b %h wait %0d want v1 h0 000000d0 2", got, hit,
               instr, n);
    end
    step();
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_pending_ready got %b want 0", req_ready);
    end
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_after_ready got %b want 1", req_ready);
    end
    do_req(32'h80, got, instr, hit);
    checks++;
    if ({got, hit, instr} !== {1'b1, 1'b0, 32'hD0}) begin
      errors++;
      $display("FAIL flush_refill_remiss got v%b h%b %h want v1 h0 000000d0", got, hit, instr);
    end
  endtask

  task automatic test_ack_gaps();
    logic [6:0]  pat = 7'b1011001;
    logic        ok, got, hit, all_req;
    logic [31:0] instr;
    mem_ack  = 1'b0;
    mem_base = 32'hE0;
    issue(32'h10C, ok);
    all_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mem_ack = pat[i];
      all_req = all_req & mem_req;
      step();
    end
    mem_ack = 1'b0;
    checks++;
    if (all_req !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL gaps_memreq got held %b after %b want 1 0", all_req, mem_req);
    end
    checks++;
    if ({resp_valid, resp_hit, resp_instr} !== {1'b1, 1'b0, 32'hE3}) begin
      errors++;
      $display("FAIL gaps_resp got v%b h%b %h want v1 h0 000000e3", resp_valid, resp_hit,
               resp_instr);
    end
    step();
    mem_base = 32'hFF00;
    for (int i = 0; i < 3; i++) begin
      do_req(32'h100 + 32'(4 * i), got, instr, hit);
      checks++;
      if ({got, hit, instr} !== {1'b1, 1'b1, 32'hE0 + 32'(i)}) begin
        errors++;
        $display("FAIL gaps_word%0d got v%b h%b %h want v1 h1 %h", i, got, hit, instr,
                 32'hE0 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    logic        ok, got, hit;
    logic [31:0] instr;
    mem_ack  = 1'b1;
    mem_base = 32'h0;
    issue(32'h200, ok);
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || miss_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid got mreq %b mc %0d want 0 0", mem_req, miss_count);
    end
    step();
    reset_n  = 1'b1;
    mem_base = 32'h50;
    do_req(32'h200, got, instr, hit);
    checks++;
    if ({got, hit, instr} !== {1'b1, 1'b0, 32'h50}) begin
      errors++;
      $display("FAIL reset_mid_remiss got v%b h%b %h want v1 h0 00000050", got, hit, instr);
    end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_back_to_back();
    test_lru();
    test_flush_idle();
    test_flush_refill();
    test_ack_gaps();
    test_reset_mid_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
